aer_tx: RTL and testbench
=========================

Name: aer_tx

Overview:
- AER output transmitter: the send side of the same 24-bit address-event interface that the input path receives into its FIFO.
- Pops events from an upstream 24-bit synchronous FIFO (same type as the input-side FIFO).
- Presents each event on a parallel address bus and completes a 4-phase req/ack handshake with an off-chip or downstream receiver.
- Sits between the accelerator's output event FIFO and the chip-level AER pins.

Parameters:
- DATA_W, 24, event address width; matches FIFO word width.
- SETUP_CYC, 2, clocks aer_addr is held stable before aer_req rises (1..15).
- TIMEOUT_CYC, 1024, max clocks spent waiting on any single ack edge before abort.
- SYNC_STAGES, 2, flip-flop stages on the asynchronous aer_ack input (>=2).
- CNT_W, 16, width of the sent-event counter.

Ports:
- clk, in, 1, system clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- enable, in, 1, when 0 no new event is fetched; an in-flight handshake still completes.
- fifo_empty, in, 1, upstream FIFO empty flag.
- fifo_dout, in, DATA_W, upstream FIFO read data; valid one clock after fifo_rd_en.
- fifo_rd_en, out, 1, one-clock pop strobe to the FIFO.
- aer_addr, out, DATA_W, event address; registered output.
- aer_req, out, 1, request; registered output.
- aer_ack, in, 1, acknowledge from receiver; asynchronous to clk.
- busy, out, 1, high in any state other than IDLE.
- sent_pulse, out, 1, one-clock pulse per completed handshake.
- timeout_err, out, 1, one-clock pulse when a handshake is aborted.
- sent_count, out, CNT_W, completed events; wraps at 2^CNT_W.

Behaviour:
- Reset (rst=0, async):
  - State=IDLE.
  - fifo_rd_en, aer_req, busy, sent_pulse, timeout_err = 0.
  - aer_addr = 0, sent_count = 0.
  - Synchronizer flops cleared; all counters cleared.
  - Reset asserted mid-handshake drops aer_req immediately; the event is lost.
- aer_ack is sampled only through the SYNC_STAGES synchronizer; ack_s is the synchronized value.
- FSM states and transitions:
  - IDLE: if enable && !fifo_empty, assert fifo_rd_en for exactly one clock, go to FETCH. Otherwise stay.
  - FETCH: wait one clock for registered FIFO data, go to LOAD.
  - LOAD: aer_addr <= fifo_dout, clear the wait counter, go to SETUP.
  - SETUP: count SETUP_CYC clocks with aer_addr stable. Then aer_req <= 1 and go to REQ.
  - REQ: wait for ack_s==1, then aer_req <= 0 and go to RELEASE. If the wait counter reaches TIMEOUT_CYC first: aer_req <= 0, pulse timeout_err, go to IDLE; the event is dropped and not counted.
  - RELEASE: wait counter restarts at entry. On ack_s==0: pulse sent_pulse, increment sent_count, go to IDLE. On timeout: pulse timeout_err, go to IDLE.
- Invariants:
  - aer_addr never changes while aer_req=1 or while in RELEASE.
  - aer_req is never high in IDLE, FETCH, LOAD or SETUP.
- Latency: fifo_rd_en to aer_req rise = 3+SETUP_CYC clocks. This is 5 clocks at default.
- Minimum event period: 5+SETUP_CYC+2*SYNC_STAGES clocks with an immediately responding receiver.
- fifo_rd_en is never asserted while fifo_empty=1, and never asserted outside IDLE.
- enable drop mid-transfer: the current event completes normally; no further fetch.
- ack_s already high when entering REQ (receiver stuck): the handshake proceeds on the level. This is legal 4-phase behaviour.
- sent_count wraps to 0 after 2^CNT_W-1; no flag is raised.
- Simultaneous ack edge and timeout in the same clock: the ack wins.
- aer_ack glitches shorter than one clock may be missed. The receiver must hold ack until req falls.

Test Plan:
- Single event: FIFO holds 24'hABCDEF, receiver acks 3 clocks after req and drops ack 3 clocks after req falls -> one fifo_rd_en pulse; aer_addr=24'hABCDEF from LOAD onward; aer_req high 5 clocks after rd_en; one sent_pulse; sent_count=1.
- Burst: 16 events 24'h000000, 24'h0000F1, 24'h0001E2, ... (step 24'hF1) back-to-back -> emitted in FIFO order with no duplicates or skips; sent_count=16; addr stable throughout every req-high window.
- Empty/enable: fifo_empty=1 for 100 clocks -> fifo_rd_en never asserted, busy=0. Then enable=0 with a non-empty FIFO -> no rd_en. Drop enable during REQ -> that event completes, none follow.
- Timeout: receiver never acks, TIMEOUT_CYC=1024 -> aer_req falls after 1024 clocks in REQ; timeout_err pulses once; sent_count unchanged; the next event starts normally.
- Reset mid-handshake: assert rst while aer_req=1 -> aer_req, busy, sent_count go to 0 asynchronously. After release, the next FIFO word is transmitted correctly.
- Counter wrap with CNT_W=4: send 17 events -> sent_count reads 1 after the 17th sent_pulse.

Source files
------------

// File: rtl/aer_tx.sv
// rtl/aer_tx.sv - AER event transmitter: FIFO pop, address setup, 4-phase req/ack handshake
module aer_tx #(
  parameter int DATA_W      = 24,
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] aer_addr,
  output logic              aer_req,
  input  logic              aer_ack,
  output logic              busy,
  output logic              sent_pulse,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  sent_count
);

  // One counter serves both the setup delay and the per-edge ack timeout.
  localparam int MAX_WAIT = (TIMEOUT_CYC > SETUP_CYC) ? TIMEOUT_CYC : SETUP_CYC;
  localparam int WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] SETUP_LAST   = WAIT_W'(SETUP_CYC - 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SETUP,
    S_REQ,
    S_RELEASE
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [DATA_W-1:0]       addr_q, addr_d;
  logic                    req_q, req_d;
  logic                    sent_q, sent_d;
  logic                    tmo_q, tmo_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    ack_s;
  logic                    fetch_go;

  assign ack_s    = sync_q[SYNC_STAGES-1];
  assign fetch_go = enable && !fifo_empty;

  // The pop strobe is combinational so FIFO data lands in FETCH; it is masked
  // during reset so no word is consumed while the FSM is held.
  assign fifo_rd_en  = rst && (state_q == S_IDLE) && fetch_go;
  assign aer_addr    = addr_q;
  assign aer_req     = req_q;
  assign busy        = (state_q != S_IDLE);
  assign sent_pulse  = sent_q;
  assign timeout_err = tmo_q;
  assign sent_count  = count_q;

  // Shift the asynchronous ack through the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], aer_ack};
  end

  // Next-state logic and registered outputs of the handshake sequencer.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    req_d   = req_q;
    sent_d  = 1'b0;
    tmo_d   = 1'b0;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (fetch_go) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        addr_d  = fifo_dout;
        wait_d  = '0;
        state_d = S_SETUP;
      end
      S_SETUP: begin
        if (wait_q == SETUP_LAST) begin
          req_d   = 1'b1;
          wait_d  = '0;
          state_d = S_REQ;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_REQ: begin
        // Ack is tested first so it wins over a timeout in the same clock.
        if (ack_s) begin
          req_d   = 1'b0;
          wait_d  = '0;
          state_d = S_RELEASE;
        end else if (wait_q == TIMEOUT_LAST) begin
          req_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!ack_s) begin
          sent_d  = 1'b1;
          count_d = count_q + 1'b1;
          state_d = S_IDLE;
        end else if (wait_q == TIMEOUT_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops req at once and loses the event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sync_q  <= '0;
      wait_q  <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      sent_q  <= 1'b0;
      tmo_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      sent_q  <= sent_d;
      tmo_q   <= tmo_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_aer_tx.sv
// tb/tb_aer_tx.sv - self-checking bench for aer_tx with a timeline reference model
module tb_aer_tx;

  localparam int SETUP = 2;
  localparam int TMO   = 1024;
  localparam int SYNC  = 2;
  localparam int CW    = 4;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          fifo_empty;
  logic [23:0]   fifo_dout;
  logic          fifo_rd_en;
  logic [23:0]   aer_addr;
  logic          aer_req;
  logic          aer_ack;
  logic          busy;
  logic          sent_pulse;
  logic          timeout_err;
  logic [CW-1:0] sent_count;

  aer_tx #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .aer_addr(aer_addr),
    .aer_req(aer_req), .aer_ack(aer_ack), .busy(busy), .sent_pulse(sent_pulse),
    .timeout_err(timeout_err), .sent_count(sent_count)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [23:0] q[$];
  logic [23:0] mq[$];
  logic [23:0] seen[$];
  int          sp_seen = 0;
  int          te_seen = 0;
  int          last_rd_n = -1;
  int          last_rise_n = -1;
  int          ack_dly = 0;
  int          rel_dly = 0;
  bit          rx_mute = 0;

  // model state: timestamps of the current event rather than an FSM
  bit          m_busy = 0;
  bit          m_rel = 0;
  int          t_rd = 0;
  int          t_rel = 0;
  logic [23:0] m_word = '0;
  logic [23:0] m_addr = '0;
  logic [CW-1:0] m_cnt = '0;
  bit          m_sp = 0;
  bit          m_te = 0;
  logic        ackh [0:63];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expire(input string name);
    n_chk++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [23:0] w);
    q.push_back(w);
    mq.push_back(w);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      tick();
      if (q.size() == 0 && !busy && !fifo_rd_en) break;
    end
    if (k == budget) expire("drain");
    repeat (2) tick();
  endtask

  task automatic wait_req(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      tick();
      if (aer_req) break;
    end
    if (k == budget) expire("wait_req");
  endtask

  // Synchronous FIFO: pop decided by rd_en in a cycle, data appears next cycle.
  initial begin : fifo_model
    bit pop;
    fifo_dout  = '0;
    fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      pop = fifo_rd_en && rst;
      @(posedge clk);
      #1;
      if (pop && q.size() > 0) fifo_dout = q.pop_front();
      #1;
      fifo_empty = (q.size() == 0);
    end
  end

  // Receiver: raises ack ack_dly clocks after req, drops it rel_dly clocks after req falls.
  initial begin : receiver
    int c;
    c = 0;
    aer_ack = 1'b0;
    forever begin
      tick();
      if (!aer_ack) begin
        if (aer_req && !rx_mute) begin
          if (c >= ack_dly) begin aer_ack = 1'b1; c = 0; end
          else c++;
        end else c = 0;
      end else begin
        if (!aer_req) begin
          if (c >= rel_dly) begin aer_ack = 1'b0; c = 0; end
          else c++;
        end else c = 0;
      end
    end
  end

  // Per-cycle compare against the timeline model.
  initial begin : compare
    int   n;
    bit   e_rd, e_req, a_s, prev_req;
    n = 0;
    prev_req = 0;
    for (int i = 0; i < 64; i++) ackh[i] = 1'b0;
    forever begin
      @(negedge clk);
      ackh[n % 64] = rst ? aer_ack : 1'b0;
      if (!rst) begin
        m_busy = 0; m_rel = 0; m_addr = '0; m_cnt = '0; m_sp = 0; m_te = 0;
        prev_req = 0;
      end else begin
        e_req = m_busy && !m_rel && (n >= t_rd + 3 + SETUP);
        e_rd  = !m_busy && enable && !fifo_empty;
        chk("rd_en", fifo_rd_en, e_rd);
        chk("busy", busy, m_busy);
        chk("aer_req", aer_req, e_req);
        chk("aer_addr", aer_addr, m_addr);
        chk("sent_pulse", sent_pulse, m_sp);
        chk("timeout_err", timeout_err, m_te);
        chk("sent_count", sent_count, m_cnt);
        if (fifo_rd_en) last_rd_n = n;
        if (aer_req && !prev_req) begin
          seen.push_back(aer_addr);
          last_rise_n = n;
        end
        prev_req = aer_req;
        if (sent_pulse) sp_seen++;
        if (timeout_err) te_seen++;
        a_s  = (n >= SYNC) ? ackh[(n - SYNC) % 64] : 1'b0;
        m_sp = 0;
        m_te = 0;
        if (!m_busy) begin
          if (e_rd && mq.size() > 0) begin
            m_busy = 1; m_rel = 0; t_rd = n; m_word = mq.pop_front();
          end
        end else begin
          if (n + 1 == t_rd + 3) m_addr = m_word;
          if (e_req) begin
            if (a_s) begin m_rel = 1; t_rel = n + 1; end
            else if (n - (t_rd + 3 + SETUP) + 1 >= TMO) begin m_busy = 0; m_te = 1; end
          end else if (m_rel) begin
            if (!a_s) begin m_busy = 0; m_sp = 1; m_cnt = m_cnt + 1'b1; end
            else if (n - t_rel + 1 >= TMO) begin m_busy = 0; m_te = 1; end
          end
        end
      end
      n++;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int            rd_cnt, busy_cnt, hi, sp0, te0, k;
    logic [CW-1:0] cnt0;
    logic [23:0]   w;
    logic [23:0]   exp_words[$];

    rst = 1'b0;
    enable = 1'b0;
    repeat (3) tick();
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_req", aer_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", aer_addr, 0);
    chk("rst_count", sent_count, 0);
    chk("rst_pulses", {sent_pulse, timeout_err}, 0);
    rst = 1'b1;

    // empty FIFO with enable high
    enable = 1'b1;
    rd_cnt = 0; busy_cnt = 0;
    repeat (100) begin
      tick();
      if (fifo_rd_en) rd_cnt++;
      if (busy) busy_cnt++;
    end
    chk("empty_rd_en", rd_cnt, 0);
    chk("empty_busy", busy_cnt, 0);

    // single event
    ack_dly = 3; rel_dly = 3;
    sp0 = sp_seen;
    seen.delete();
    push(24'hABCDEF);
    wait_drain(200);
    chk("single_latency", last_rise_n - last_rd_n, 5);
    chk("single_addr", seen.size() > 0 ? seen[0] : 24'h0, 24'hABCDEF);
    chk("single_sent", sp_seen - sp0, 1);
    chk("single_count", sent_count, 1);

    // burst of 16, immediate receiver; 17 events so far wrap a 4-bit count to 1
    ack_dly = 0; rel_dly = 0;
    seen.delete();
    for (int i = 0; i < 16; i++) begin
      w = 24'(i) * 24'hF1;
      push(w);
    end
    wait_drain(1000);
    chk("burst_n", seen.size(), 16);
    for (int i = 0; i < 16 && i < seen.size(); i++) begin
      w = 24'(i) * 24'hF1;
      chk("burst_addr", seen[i], w);
    end
    chk("wrap_count", sent_count, 1);

    // enable low with data waiting, then drop enable during REQ
    enable = 1'b0;
    push(24'h123456);
    rd_cnt = 0; busy_cnt = 0;
    repeat (50) begin
      tick();
      if (fifo_rd_en) rd_cnt++;
      if (busy) busy_cnt++;
    end
    chk("dis_rd_en", rd_cnt, 0);
    chk("dis_busy", busy_cnt, 0);
    push(24'h654321);
    ack_dly = 4;
    sp0 = sp_seen;
    enable = 1'b1;
    wait_req(50);
    enable = 1'b0;
    for (k = 0; k < 100 && busy; k++) tick();
    if (k == 100) expire("enable_drop_idle");
    rd_cnt = 0;
    repeat (30) begin
      tick();
      if (fifo_rd_en) rd_cnt++;
    end
    chk("drop_rd_en", rd_cnt, 0);
    chk("drop_left", q.size(), 1);
    chk("drop_sent", sp_seen - sp0, 1);
    enable = 1'b1;
    wait_drain(200);

    // timeout: receiver never answers
    rx_mute = 1;
    te0 = te_seen;
    cnt0 = sent_count;
    push(24'hDEAD01);
    wait_req(50);
    hi = 0;
    while (aer_req && hi < 1200) begin
      hi++;
      tick();
    end
    repeat (3) tick();
    chk("tmo_req_cycles", hi, TMO);
    chk("tmo_pulses", te_seen - te0, 1);
    chk("tmo_count", sent_count, cnt0);
    rx_mute = 0;
    seen.delete();
    push(24'h0BEEF0);
    wait_drain(200);
    chk("after_tmo_addr", seen.size() > 0 ? seen[0] : 24'h0, 24'h0BEEF0);
    chk("after_tmo_count", sent_count, cnt0 + 1'b1);

    // reset in the middle of a handshake
    ack_dly = 6;
    push(24'hC0FFEE);
    wait_req(50);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", aer_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", sent_count, 0);
    tick();
    tick();
    rst = 1'b1;
    ack_dly = 2;
    seen.delete();
    push(24'h5A5A5A);
    wait_drain(300);
    chk("post_rst_addr", seen.size() > 0 ? seen[0] : 24'h0, 24'h5A5A5A);
    chk("post_rst_count", sent_count, 1);

    // randomized traffic
    seen.delete();
    exp_words.delete();
    for (int i = 0; i < 40; i++) begin
      ack_dly = $urandom_range(0, 6);
      rel_dly = $urandom_range(0, 6);
      w = 24'($urandom);
      exp_words.push_back(w);
      push(w);
      repeat ($urandom_range(0, 15)) begin
        enable = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    enable = 1'b1;
    wait_drain(5000);
    chk("rand_n", seen.size(), exp_words.size());
    for (int i = 0; i < exp_words.size() && i < seen.size(); i++)
      chk("rand_order", seen[i], exp_words[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
